// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel deserializer with comma-based symbol alignment.
// It hunts for COM, locks after SYNC_COMS aligned COMs, and then delivers non-COM symbols.
module serial_paralelo_sync #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] COM       = 8'hBC,
    parameter int               SYNC_COMS = 4,
    parameter int               MAX_GAP   = 16
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             com_det,
    output logic             sync_lost
);

    localparam int BCW = $clog2(WIDTH);
    localparam int CCW = $clog2(SYNC_COMS + 1);
    localparam int GCW = $clog2(MAX_GAP + 1);

    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [CCW-1:0] SYNC_CNT = CCW'(SYNC_COMS);
    localparam logic [GCW-1:0] GAP_MAX  = GCW'(MAX_GAP);

    typedef enum logic [1:0] {HUNT, LOCKING, ACTIVE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CCW-1:0]   com_cnt_q, com_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             active_q, active_d;
    logic             com_det_q, com_det_d;
    logic             sync_lost_q, sync_lost_d;

    logic boundary;
    logic is_com;

    // Decisions look at the already-updated shift register, so every output
    // lands one cycle after the edge that sampled a symbol's last bit.
    assign sr_d     = {sr_q[WIDTH-2:0], data_in};
    assign boundary = (bit_cnt_q == LAST_BIT);
    assign is_com   = (sr_q == COM);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + 1'b1;
        com_cnt_d   = com_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        com_det_d   = 1'b0;
        sync_lost_d = 1'b0;

        case (state_q)
            HUNT: begin
                bit_cnt_d = '0;
                if (is_com) begin
                    com_cnt_d = CCW'(1);
                    com_det_d = 1'b1;
                    if (SYNC_COMS == 1) begin
                        state_d   = ACTIVE;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = LOCKING;
                    end
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (is_com) begin
                        com_det_d = 1'b1;
                        com_cnt_d = com_cnt_q + 1'b1;
                        if (com_cnt_d == SYNC_CNT) begin
                            state_d   = ACTIVE;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        state_d   = HUNT;
                        com_cnt_d = '0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    if (is_com) begin
                        com_det_d = 1'b1;
                        gap_cnt_d = '0;
                    end else if (gap_cnt_q < GAP_MAX) begin
                        data_out_d = sr_q;
                        valid_d    = 1'b1;
                        gap_cnt_d  = gap_cnt_q + 1'b1;
                    end else begin
                        sync_lost_d = 1'b1;
                        state_d     = HUNT;
                        com_cnt_d   = '0;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        active_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk_32f) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            com_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            com_det_q   <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            com_cnt_q   <= com_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
            com_det_q   <= com_det_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign active    = active_q;
    assign com_det   = com_det_q;
    assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Scoreboard bench for serial_paralelo_sync at default parameters.
// Each symbol sent queues the pulses it should cause; a monitor pops them as the DUT fires.
module tb_serial_paralelo_sync;

    localparam int E_COM  = 1;
    localparam int E_RISE = 2;
    localparam int E_VAL  = 4;
    localparam int E_LOST = 8;
    localparam int E_FALL = 16;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } val_t;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, active, com_det, sync_lost;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_cyc    = 0;
    logic rst_edge    = 1'b0;
    logic prev_valid  = 1'b0;
    logic prev_act    = 1'b0;

    int   com_q[$];
    int   lost_q[$];
    int   rise_q[$];
    int   fall_q[$];
    val_t val_q[$];

    serial_paralelo_sync dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active),
        .com_det  (com_det),
        .sync_lost(sync_lost)
    );

    always #5 clk_32f = ~clk_32f;

    always @(posedge clk_32f) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every observed pulse or active edge must match a queued expectation.
    always @(negedge clk_32f) begin
        if (com_det) begin
            if (com_q.size() == 0) check("com_det_unexpected", 1, 0);
            else check("com_det_cycle", cyc, com_q.pop_front());
        end
        if (valid_out) begin
            check("valid_back_to_back", prev_valid, 0);
            if (val_q.size() == 0) check("valid_unexpected", 1, 0);
            else begin
                val_t e;
                e = val_q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("data_out", data_out, e.data);
            end
        end
        if (sync_lost) begin
            if (lost_q.size() == 0) check("sync_lost_unexpected", 1, 0);
            else check("sync_lost_cycle", cyc, lost_q.pop_front());
        end
        if (active && !prev_act) begin
            if (rise_q.size() == 0) check("active_rise_unexpected", 1, 0);
            else check("active_rise_cycle", cyc, rise_q.pop_front());
        end
        if (!active && prev_act && !rst_edge) begin
            if (fall_q.size() == 0) check("active_fall_unexpected", 1, 0);
            else check("active_fall_cycle", cyc, fall_q.pop_front());
        end
        prev_valid <= valid_out;
        prev_act   <= active;
    end

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
        last_cyc = cyc;
    endtask

    task automatic send_sym(input logic [7:0] sym, input int flags);
        val_t e;
        for (int i = 7; i >= 0; i--) send_bit(sym[i]);
        if ((flags & E_COM)  != 0) com_q.push_back(last_cyc + 1);
        if ((flags & E_RISE) != 0) rise_q.push_back(last_cyc + 1);
        if ((flags & E_LOST) != 0) lost_q.push_back(last_cyc + 1);
        if ((flags & E_FALL) != 0) fall_q.push_back(last_cyc + 1);
        if ((flags & E_VAL)  != 0) begin
            e.cyc  = last_cyc + 1;
            e.data = sym;
            val_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk_32f);
            reset   = 1'b1;
            data_in = ~data_in;
        end
        @(negedge clk_32f);
        reset   = 1'b0;
        data_in = 1'b0;
        check("rst_data_out", data_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_active", active, 0);
        check("rst_com_det", com_det, 0);
        check("rst_sync_lost", sync_lost, 0);
    endtask

    task automatic lock_up();
        send_sym(8'hBC, E_COM);
        send_sym(8'hBC, E_COM);
        send_sym(8'hBC, E_COM);
        send_sym(8'hBC, E_COM | E_RISE);
    endtask

    // Fewer than WIDTH idle bits, so no boundary is crossed while ACTIVE.
    task automatic flush(input string tag);
        repeat (4) send_bit(1'b0);
        check({tag, "_com_left"}, com_q.size(), 0);
        check({tag, "_val_left"}, val_q.size(), 0);
        check({tag, "_lost_left"}, lost_q.size(), 0);
        check({tag, "_rise_left"}, rise_q.size(), 0);
        check({tag, "_fall_left"}, fall_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Reset with toggling data.
        do_reset(3);

        // Basic lock and first data symbol.
        lock_up();
        send_sym(8'h55, E_VAL);
        flush("lock");
        check("lock_active", active, 1);

        // Alignment at a 3-bit offset.
        do_reset(1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        lock_up();
        send_sym(8'hA3, E_VAL);
        flush("offset");

        // Non-COM while locking drops back to hunting.
        do_reset(1);
        send_sym(8'hBC, E_COM);
        send_sym(8'hBC, E_COM);
        send_sym(8'h12, 0);
        flush("relock");
        check("relock_active", active, 0);

        // Gap limit: 16 accepted, 17th discarded with sync loss.
        do_reset(1);
        lock_up();
        for (int i = 0; i < 16; i++) send_sym(8'(8'h10 + i), E_VAL);
        send_sym(8'h20, E_LOST | E_FALL);
        flush("gap");
        check("gap_active", active, 0);

        // A COM inside the stream restarts the gap count.
        do_reset(1);
        lock_up();
        for (int i = 0; i < 10; i++) send_sym(8'(8'h30 + i), E_VAL);
        send_sym(8'hBC, E_COM);
        for (int i = 0; i < 10; i++) send_sym(8'(8'h60 + i), E_VAL);
        flush("gap_reset");
        check("gap_reset_active", active, 1);

        // Reset mid-symbol while ACTIVE, then a full re-lock is required.
        do_reset(1);
        lock_up();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset(1);
        send_sym(8'hBC, E_COM);
        send_sym(8'hBC, E_COM);
        send_sym(8'hBC, E_COM);
        check("midrst_active_3com", active, 0);
        send_sym(8'hBC, E_COM | E_RISE);
        flush("midrst");
        check("midrst_active", active, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
